// File: rtl/vending_pkg.sv
// Shared coin encodings, coin values and dispenser state encoding for the vending datapath.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_5    = 2'b10,
        COIN_10   = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DONE
    } disp_state_t;

    function automatic logic [4:0] coin_value(input coin_t c);
        case (c)
            COIN_1:  return 5'd1;
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: the dispenser presents a coin request, the hopper acknowledges it.
interface change_dispenser_if;

    logic       coin_out_valid;
    logic [1:0] coin_out_type;
    logic       coin_out_ack;

    modport master (output coin_out_valid, output coin_out_type, input coin_out_ack);
    modport slave  (input coin_out_valid, input coin_out_type, output coin_out_ack);

endinterface

// File: rtl/coin_inventory.sv
// Three saturating per-denomination coin counters; index 0/1/2 holds the 1/5/10 coins.
module coin_inventory
    import vending_pkg::*;
#(
    parameter int unsigned INV_W    = 4,
    parameter int unsigned INV_INIT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  coin_t            i_inc,
    input  coin_t            i_dec,
    output logic [INV_W-1:0] o_cnt1,
    output logic [INV_W-1:0] o_cnt5,
    output logic [INV_W-1:0] o_cnt10
);

    localparam logic [INV_W-1:0] CNT_MAX  = '1;
    localparam logic [INV_W-1:0] CNT_INIT = INV_W'(INV_INIT);

    logic [INV_W-1:0] r_cnt [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) r_cnt[i] <= CNT_INIT;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                // an insert and a payout of the same coin in one cycle cancel out
                if (i_inc == coin_t'(2'(i + 1)) && i_dec != coin_t'(2'(i + 1))) begin
                    if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (i_dec == coin_t'(2'(i + 1)) && i_inc != coin_t'(2'(i + 1))) begin
                    if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign o_cnt1  = r_cnt[0];
    assign o_cnt5  = r_cnt[1];
    assign o_cnt10 = r_cnt[2];

endmodule

// File: rtl/change_dispenser.sv
// Computes change on a start pulse and pays it out greedily (10/5/1) to the coin hopper,
// limited by the coin inventory; reports completion, shortfall and hopper ack timeouts.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int unsigned INV_W       = 4,
    parameter int unsigned INV_INIT    = 5,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                calculate_change,
    input  logic                refund_all,
    input  logic [4:0]          current_amount,
    input  logic [4:0]          selected_price,
    input  logic [1:0]          coin_in,
    change_dispenser_if.master  hop,
    output logic                busy,
    output logic                done,
    output logic                change_short,
    output logic                hopper_fault,
    output logic [4:0]          change_paid
);

    disp_state_t      r_state, w_next;
    logic [4:0]       r_remaining, r_paid, w_change;
    coin_t            r_coin, w_pick, w_dec;
    logic             r_short, r_fault, w_timeout;
    logic [3:0]       r_tcnt;
    logic [INV_W-1:0] w_cnt1, w_cnt5, w_cnt10;

    assign w_change = (refund_all || current_amount < selected_price)
                    ? current_amount : current_amount - selected_price;
    assign w_timeout = (r_tcnt == 4'(ACK_TIMEOUT - 1));
    assign w_dec     = (r_state == ST_ISSUE && hop.coin_out_ack) ? r_coin : COIN_NONE;

    coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (coin_t'(coin_in)),
        .i_dec   (w_dec),
        .o_cnt1  (w_cnt1),
        .o_cnt5  (w_cnt5),
        .o_cnt10 (w_cnt10)
    );

    always_comb begin
        w_pick = COIN_NONE;
        if (r_remaining >= 5'd10 && w_cnt10 != '0)     w_pick = COIN_10;
        else if (r_remaining >= 5'd5 && w_cnt5 != '0)  w_pick = COIN_5;
        else if (r_remaining != '0 && w_cnt1 != '0)    w_pick = COIN_1;
    end

    always_comb begin
        w_next             = r_state;
        hop.coin_out_valid = 1'b0;
        hop.coin_out_type  = COIN_NONE;
        busy               = 1'b0;
        done               = 1'b0;
        case (r_state)
            ST_IDLE:   if (calculate_change) w_next = ST_SELECT;
            ST_SELECT: begin
                busy   = 1'b1;
                w_next = (w_pick == COIN_NONE) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                busy               = 1'b1;
                hop.coin_out_valid = 1'b1;
                hop.coin_out_type  = r_coin;
                if (hop.coin_out_ack) w_next = ST_SELECT;
                else if (w_timeout)   w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_paid      <= '0;
            r_coin      <= COIN_NONE;
            r_short     <= 1'b0;
            r_fault     <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (calculate_change) begin
                    r_remaining <= w_change;
                    r_paid      <= '0;
                    r_short     <= 1'b0;
                    r_fault     <= 1'b0;
                end
                ST_SELECT: begin
                    r_coin <= w_pick;
                    r_tcnt <= '0;
                    if (r_remaining != '0 && w_pick == COIN_NONE) r_short <= 1'b1;
                end
                ST_ISSUE: begin
                    if (hop.coin_out_ack) begin
                        r_remaining <= r_remaining - coin_value(r_coin);
                        r_paid      <= r_paid + coin_value(r_coin);
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign change_short = r_short;
    assign hopper_fault = r_fault;
    assign change_paid  = r_paid;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: directed payout scenarios plus randomized traffic against a
// transaction-level model of change, greedy coin choice, inventory and ack timeout.
module tb_change_dispenser;

    localparam int TO      = 15;
    localparam int INV_MAX = 15;
    localparam int PH_IDLE = 0, PH_SEL = 1, PH_ISS = 2, PH_DONE = 3;

    logic       clk = 1'b0;
    logic       reset, calculate_change, refund_all;
    logic [4:0] current_amount, selected_price;
    logic [1:0] coin_in;
    logic       busy, done, change_short, hopper_fault;
    logic [4:0] change_paid;

    change_dispenser_if hop ();

    change_dispenser #(.INV_W(4), .INV_INIT(5), .ACK_TIMEOUT(15)) dut (
        .clk              (clk),
        .reset            (reset),
        .calculate_change (calculate_change),
        .refund_all       (refund_all),
        .current_amount   (current_amount),
        .selected_price   (selected_price),
        .coin_in          (coin_in),
        .hop              (hop),
        .busy             (busy),
        .done             (done),
        .change_short     (change_short),
        .hopper_fault     (hopper_fault),
        .change_paid      (change_paid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: inventory indexed 0/1/2 for coins 1/5/10
    int m_inv [3];
    int m_ph, m_rem, m_paid, m_val, m_wait;
    bit m_short, m_fault;
    int obs_coins [$];
    int valid_cycles;

    function automatic int idx_of(input int v);
        return (v == 1) ? 0 : (v == 5) ? 1 : 2;
    endfunction

    function automatic int code_of(input int v);
        return (v == 1) ? 1 : (v == 5) ? 2 : (v == 10) ? 3 : 0;
    endfunction

    function automatic int val_of(input int code);
        return (code == 1) ? 1 : (code == 2) ? 5 : (code == 3) ? 10 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_coins(input string name, input int exp [$]);
        string sa, se;
        bit bad;
        sa = ""; se = "";
        bad = (obs_coins.size() != exp.size());
        foreach (obs_coins[i]) sa = {sa, $sformatf(" %0d", obs_coins[i])};
        foreach (exp[i]) begin
            se = {se, $sformatf(" %0d", exp[i])};
            if (i < obs_coins.size() && obs_coins[i] != exp[i]) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s: coins got [%s ] expected [%s ]", name, sa, se);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_inv[i] = 5;
        m_ph = PH_IDLE; m_rem = 0; m_paid = 0; m_val = 0; m_wait = 0;
        m_short = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_advance();
        int inc_v, dec_v;
        bit ack;
        if (reset) begin
            model_reset();
        end else begin
            ack   = hop.coin_out_ack;
            inc_v = val_of(int'(coin_in));
            dec_v = (m_ph == PH_ISS && ack) ? m_val : 0;
            case (m_ph)
                PH_IDLE: if (calculate_change) begin
                    m_rem = (refund_all || current_amount < selected_price)
                          ? int'(current_amount) : int'(current_amount) - int'(selected_price);
                    m_paid = 0; m_short = 1'b0; m_fault = 1'b0;
                    m_ph = PH_SEL;
                end
                PH_SEL: begin
                    if (m_rem == 0) m_ph = PH_DONE;
                    else begin
                        m_val = 0;
                        if (m_rem >= 10 && m_inv[2] > 0)     m_val = 10;
                        else if (m_rem >= 5 && m_inv[1] > 0) m_val = 5;
                        else if (m_inv[0] > 0)               m_val = 1;
                        if (m_val == 0) begin
                            m_short = 1'b1; m_ph = PH_DONE;
                        end else begin
                            m_wait = 0; m_ph = PH_ISS;
                        end
                    end
                end
                PH_ISS: begin
                    m_wait++;
                    if (ack) begin
                        m_rem -= m_val; m_paid += m_val; m_ph = PH_SEL;
                    end else if (m_wait == TO) begin
                        m_fault = 1'b1; m_ph = PH_DONE;
                    end
                end
                default: m_ph = PH_IDLE;
            endcase
            if (inc_v != 0 && inc_v != dec_v && m_inv[idx_of(inc_v)] < INV_MAX) m_inv[idx_of(inc_v)]++;
            if (dec_v != 0 && dec_v != inc_v) m_inv[idx_of(dec_v)]--;
        end
    endtask

    task automatic check_outputs();
        chk("valid",  int'(hop.coin_out_valid), int'(m_ph == PH_ISS));
        chk("type",   int'(hop.coin_out_type),  (m_ph == PH_ISS) ? code_of(m_val) : 0);
        chk("busy",   int'(busy),  int'(m_ph == PH_SEL || m_ph == PH_ISS));
        chk("done",   int'(done),  int'(m_ph == PH_DONE));
        chk("short",  int'(change_short), int'(m_short));
        chk("fault",  int'(hopper_fault), int'(m_fault));
        chk("paid",   int'(change_paid),  m_paid);
        chk("inv1",   int'(dut.u_inv.o_cnt1),  m_inv[0]);
        chk("inv5",   int'(dut.u_inv.o_cnt5),  m_inv[1]);
        chk("inv10",  int'(dut.u_inv.o_cnt10), m_inv[2]);
    endtask

    // inputs are set at the negedge; outputs are checked at the following negedge
    task automatic tick();
        if (hop.coin_out_valid) valid_cycles++;
        if (hop.coin_out_valid && hop.coin_out_ack) obs_coins.push_back(val_of(int'(hop.coin_out_type)));
        model_advance();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        calculate_change = 1'b0; refund_all = 1'b0;
        current_amount = '0; selected_price = '0; coin_in = '0;
        hop.coin_out_ack = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int ack_mode);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (done) seen = 1'b1;
            else begin
                hop.coin_out_ack = hop.coin_out_valid &&
                    (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 2) != 0));
                tick();
            end
        end
        hop.coin_out_ack = 1'b0;
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 200 cycles");
        end
    endtask

    task automatic run_txn(input int amt, input int price, input bit refund, input int ack_mode);
        obs_coins.delete();
        valid_cycles = 0;
        calculate_change = 1'b1;
        current_amount = 5'(amt); selected_price = 5'(price); refund_all = refund;
        tick();
        calculate_change = 1'b0;
        wait_done(ack_mode);
    endtask

    initial begin
        int q [$];
        bit stall;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs();
        tick();
        reset = 1'b0;
        tick();

        // 1: 23-15 with full inventory
        run_txn(23, 15, 1'b0, 2);
        q = '{5, 1, 1, 1};
        chk_coins("t1_coins", q);
        chk("t1_paid", int'(change_paid), 8);
        chk("t1_short", int'(change_short), 0);
        chk("t1_done", int'(done), 1);
        tick();

        // 2: refund of the whole 26
        do_reset();
        run_txn(26, 20, 1'b1, 1);
        q = '{10, 10, 5, 1};
        chk_coins("t2_coins", q);
        chk("t2_paid", int'(change_paid), 26);
        tick();

        // 3: drain to inv10=0, inv5=1, inv1=2, then ask for 9
        do_reset();
        run_txn(30, 0, 1'b1, 1); tick();
        run_txn(20, 0, 1'b1, 1); tick();
        run_txn(20, 0, 1'b1, 1); tick();
        run_txn(3, 0, 1'b1, 1);  tick();
        chk("t3_inv10", int'(dut.u_inv.o_cnt10), 0);
        chk("t3_inv5",  int'(dut.u_inv.o_cnt5),  1);
        chk("t3_inv1",  int'(dut.u_inv.o_cnt1),  2);
        run_txn(9, 0, 1'b0, 2);
        q = '{5, 1, 1};
        chk_coins("t3_coins", q);
        chk("t3_short", int'(change_short), 1);
        chk("t3_paid", int'(change_paid), 7);
        tick();
        chk("t3_short_held", int'(change_short), 1);

        // 4: hopper never acks
        do_reset();
        run_txn(10, 0, 1'b0, 0);
        chk("t4_fault", int'(hopper_fault), 1);
        chk("t4_valid_cycles", valid_cycles, TO);
        chk("t4_valid_low", int'(hop.coin_out_valid), 0);
        chk("t4_paid", int'(change_paid), 0);
        chk("t4_inv10", int'(dut.u_inv.o_cnt10), 5);
        tick();
        chk("t4_fault_held", int'(hopper_fault), 1);

        // 5: insert a 1 in the same cycle a 1 is paid out, then saturate
        do_reset();
        calculate_change = 1'b1; current_amount = 5'd1; selected_price = 5'd0;
        tick();
        calculate_change = 1'b0;
        tick();
        chk("t5_valid", int'(hop.coin_out_valid), 1);
        hop.coin_out_ack = 1'b1; coin_in = 2'b01;
        tick();
        hop.coin_out_ack = 1'b0; coin_in = 2'b00;
        chk("t5_inv1_net", int'(dut.u_inv.o_cnt1), 5);
        wait_done(1);
        tick();
        coin_in = 2'b01;
        for (int i = 0; i < 20; i++) tick();
        coin_in = 2'b00;
        chk("t5_inv1_sat", int'(dut.u_inv.o_cnt1), 15);

        // 6: zero change timing, start while busy, reset mid-issue
        do_reset();
        calculate_change = 1'b1; current_amount = 5'd20; selected_price = 5'd20;
        tick();
        calculate_change = 1'b0;
        chk("t6_busy_n1", int'(busy), 1);
        chk("t6_done_n1", int'(done), 0);
        tick();
        chk("t6_done_n2", int'(done), 1);
        chk("t6_novalid", int'(hop.coin_out_valid), 0);
        tick();
        calculate_change = 1'b1; current_amount = 5'd5; selected_price = 5'd0;
        tick();
        calculate_change = 1'b1; current_amount = 5'd31; refund_all = 1'b1;
        tick();
        calculate_change = 1'b0; refund_all = 1'b0;
        wait_done(1);
        chk("t6_ignored_start", int'(change_paid), 5);
        tick();
        obs_coins.delete();
        calculate_change = 1'b1; current_amount = 5'd20; selected_price = 5'd0;
        tick();
        calculate_change = 1'b0;
        tick();
        hop.coin_out_ack = 1'b1;
        tick();
        hop.coin_out_ack = 1'b0;
        tick();
        chk("t6_valid_before_rst", int'(hop.coin_out_valid), 1);
        chk("t6_inv10_before_rst", int'(dut.u_inv.o_cnt10), 4);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_valid", int'(hop.coin_out_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_paid", int'(change_paid), 0);
        chk("t6_rst_inv10", int'(dut.u_inv.o_cnt10), 5);
        tick();
        reset = 1'b0;
        tick();

        // randomized traffic
        stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            calculate_change = ($urandom_range(0, 5) == 0);
            current_amount = 5'($urandom_range(0, 31));
            selected_price = 5'($urandom_range(0, 31));
            refund_all = ($urandom_range(0, 3) == 0);
            coin_in = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if (done) stall = ($urandom_range(0, 7) == 0);
            hop.coin_out_ack = hop.coin_out_valid && !stall && ($urandom_range(0, 2) != 0);
            tick();
        end
        idle_inputs();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
